// File: rtl/fpu_if.sv
// Host register bus for the FPU: byte-wide data, 4-bit address, active-low strobes,
// plus the completion handshake and status lines.
interface fpu_if;
    logic [7:0] databus_in;
    logic [7:0] databus_out;
    logic [3:0] addr;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       end_ack;
    logic       cmd_end;
    logic       busy;

    modport master (
        output databus_in, addr, cs, rd, wr, end_ack,
        input  databus_out, cmd_end, busy
    );

    modport slave (
        input  databus_in, addr, cs, rd, wr, end_ack,
        output databus_out, cmd_end, busy
    );
endinterface

// File: rtl/fpu.sv
// Register-mapped binary32 add/sub/mul unit, one result per START, completion flag
// held until the host acknowledges it.
//
//  state  | meaning
//  IDLE   | waiting for START
//  UNPACK | classify operands, resolve NaN/inf/zero cases, seed multiplier
//  EXEC   | add/sub in one cycle, or one shift-add multiply step per cycle
//  NORM   | one-bit shifts until the hidden bit sits at mant_r[26]
//  ROUND  | nearest-even rounding, carry renormalize, overflow/underflow
//  DONE   | result valid, cmd_end held until end_ack
module fpu (
    input  logic clk,
    input  logic arst,
    fpu_if.slave bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, EXEC, NORM, ROUND, DONE} state_t;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state;
    logic [31:0] op_a, op_b, result;
    logic [1:0]  opcode;
    logic        wr_prev, busy_r, cmd_end_r;
    logic        sign_r;
    logic [9:0]  exp_r;
    logic [27:0] mant_r;
    logic [47:0] mcand, prod;
    logic [23:0] mplier;
    logic [4:0]  iter_cnt;

    logic wr_act, write_pulse;
    assign wr_act      = ~bus.cs & ~bus.wr;
    assign write_pulse = wr_act & ~wr_prev;

    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sb_eff;
    assign ea     = op_a[30:23];
    assign eb     = op_b[30:23];
    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);
    assign ma     = zero_a ? 24'd0 : {1'b1, op_a[22:0]};
    assign mb     = zero_b ? 24'd0 : {1'b1, op_b[22:0]};
    assign inf_a  = (ea == 8'hFF) && (op_a[22:0] == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (op_b[22:0] == 23'd0);
    assign nan_a  = (ea == 8'hFF) && (op_a[22:0] != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (op_b[22:0] != 23'd0);
    assign sb_eff = op_b[31] ^ (opcode == 2'd1);

    logic        special;
    logic [31:0] special_res;
    always_comb begin
        special     = 1'b1;
        special_res = 32'h0;
        if (opcode == 2'd3)
            special_res = 32'h0;
        else if (nan_a | nan_b)
            special_res = QNAN;
        else if (opcode == 2'd2) begin
            if ((inf_a & zero_b) | (inf_b & zero_a)) special_res = QNAN;
            else if (inf_a | inf_b)  special_res = {op_a[31] ^ op_b[31], 8'hFF, 23'd0};
            else if (zero_a | zero_b) special_res = {op_a[31] ^ op_b[31], 31'd0};
            else special = 1'b0;
        end else begin
            if (inf_a & inf_b & (op_a[31] != sb_eff)) special_res = QNAN;
            else if (inf_a) special_res = {op_a[31], 8'hFF, 23'd0};
            else if (inf_b) special_res = {sb_eff, 8'hFF, 23'd0};
            else special = 1'b0;
        end
    end

    // Alignment: smaller operand shifted right, lost bits collapse into the sticky LSB.
    logic        a_big, s_big;
    logic [7:0]  e_big, e_small, shift_amt;
    logic [23:0] m_big, m_small;
    logic [26:0] small_ext, aligned;
    logic        sticky;
    logic [27:0] addsub;
    always_comb begin
        a_big     = (op_a[30:0] >= op_b[30:0]);
        e_big     = a_big ? ea : eb;
        e_small   = a_big ? eb : ea;
        m_big     = a_big ? ma : mb;
        m_small   = a_big ? mb : ma;
        s_big     = a_big ? op_a[31] : sb_eff;
        shift_amt = e_big - e_small;
        small_ext = {m_small, 3'b000};
        if (shift_amt >= 8'd27) begin
            aligned = 27'd0;
            sticky  = |small_ext;
        end else begin
            aligned = small_ext >> shift_amt;
            sticky  = |(small_ext & ~(27'h7FF_FFFF << shift_amt));
        end
        if (op_a[31] ^ sb_eff)
            addsub = {1'b0, m_big, 3'b000} - {1'b0, aligned[26:1], aligned[0] | sticky};
        else
            addsub = {1'b0, m_big, 3'b000} + {1'b0, aligned[26:1], aligned[0] | sticky};
    end

    logic [47:0] prod_next;
    assign prod_next = prod + (mplier[0] ? mcand : 48'd0);

    logic        round_up;
    logic [24:0] rnd_sum;
    logic [9:0]  exp_f;
    logic [22:0] frac_f;
    logic [31:0] round_res;
    always_comb begin
        round_up = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
        rnd_sum  = {1'b0, mant_r[26:3]} + {24'd0, round_up};
        exp_f    = exp_r + {9'd0, rnd_sum[24]};
        frac_f   = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
        if ($signed(exp_f) >= 10'sd255)
            round_res = {sign_r, 8'hFF, 23'd0};
        else if ($signed(exp_f) <= 10'sd0)
            round_res = {sign_r, 31'd0};
        else
            round_res = {sign_r, exp_f[7:0], frac_f};
    end

    logic [7:0] rdata;
    always_comb begin
        rdata = 8'h00;
        if (!bus.cs && !bus.rd) begin
            case (bus.addr)
                4'd0:  rdata = op_a[7:0];
                4'd1:  rdata = op_a[15:8];
                4'd2:  rdata = op_a[23:16];
                4'd3:  rdata = op_a[31:24];
                4'd4:  rdata = op_b[7:0];
                4'd5:  rdata = op_b[15:8];
                4'd6:  rdata = op_b[23:16];
                4'd7:  rdata = op_b[31:24];
                4'd8:  rdata = {6'd0, opcode};
                4'd9:  rdata = result[7:0];
                4'd10: rdata = result[15:8];
                4'd11: rdata = result[23:16];
                4'd12: rdata = result[31:24];
                4'd13: rdata = {6'd0, cmd_end_r, busy_r};
                default: rdata = 8'h00;
            endcase
        end
    end
    assign bus.databus_out = rdata;
    assign bus.busy        = busy_r;
    assign bus.cmd_end     = cmd_end_r;

    always_ff @(posedge clk) begin
        if (arst) begin
            state     <= IDLE;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            opcode    <= 2'd0;
            result    <= 32'd0;
            wr_prev   <= 1'b0;
            busy_r    <= 1'b0;
            cmd_end_r <= 1'b0;
            sign_r    <= 1'b0;
            exp_r     <= 10'd0;
            mant_r    <= 28'd0;
            mcand     <= 48'd0;
            prod      <= 48'd0;
            mplier    <= 24'd0;
            iter_cnt  <= 5'd0;
        end else begin
            wr_prev <= wr_act;
            if (write_pulse && !busy_r) begin
                case (bus.addr)
                    4'd0: op_a[7:0]   <= bus.databus_in;
                    4'd1: op_a[15:8]  <= bus.databus_in;
                    4'd2: op_a[23:16] <= bus.databus_in;
                    4'd3: op_a[31:24] <= bus.databus_in;
                    4'd4: op_b[7:0]   <= bus.databus_in;
                    4'd5: op_b[15:8]  <= bus.databus_in;
                    4'd6: op_b[23:16] <= bus.databus_in;
                    4'd7: op_b[31:24] <= bus.databus_in;
                    4'd8: opcode      <= bus.databus_in[1:0];
                    default: ;
                endcase
            end
            case (state)
                IDLE: begin
                    if (write_pulse && bus.addr == 4'd9) begin
                        state  <= UNPACK;
                        busy_r <= 1'b1;
                    end
                end
                UNPACK: begin
                    if (special) begin
                        result    <= special_res;
                        busy_r    <= 1'b0;
                        cmd_end_r <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (opcode == 2'd2) begin
                            mcand    <= {24'd0, ma};
                            mplier   <= mb;
                            prod     <= 48'd0;
                            iter_cnt <= 5'd24;
                            sign_r   <= op_a[31] ^ op_b[31];
                            exp_r    <= {2'b00, ea} + {2'b00, eb} - 10'd127;
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (opcode == 2'd2) begin
                        prod     <= prod_next;
                        mcand    <= mcand << 1;
                        mplier   <= mplier >> 1;
                        iter_cnt <= iter_cnt - 5'd1;
                        if (iter_cnt == 5'd1) begin
                            mant_r <= {prod_next[47:21], |prod_next[20:0]};
                            state  <= NORM;
                        end
                    end else begin
                        mant_r <= addsub;
                        exp_r  <= {2'b00, e_big};
                        sign_r <= s_big;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    if (mant_r == 28'd0) begin
                        result    <= 32'd0;
                        busy_r    <= 1'b0;
                        cmd_end_r <= 1'b1;
                        state     <= DONE;
                    end else if (mant_r[27]) begin
                        mant_r <= {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
                        exp_r  <= exp_r + 10'd1;
                    end else if (!mant_r[26]) begin
                        mant_r <= mant_r << 1;
                        exp_r  <= exp_r - 10'd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    result    <= round_res;
                    busy_r    <= 1'b0;
                    cmd_end_r <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (bus.end_ack) begin
                        cmd_end_r <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu.sv
// Directed vector bench for the register-mapped FPU plus handshake/reset sequences.
module tb_fpu;
    logic clk = 1'b0;
    logic arst;
    fpu_if bus_if();
    fpu dut (.clk(clk), .arst(arst), .bus(bus_if));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
    } vec_t;

    vec_t vecs [22];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.addr = a;
        bus_if.databus_in = d;
        bus_if.cs = 1'b0;
        bus_if.wr = 1'b0;
        @(negedge clk);
        bus_if.cs = 1'b1;
        bus_if.wr = 1'b1;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_if.addr = a;
        bus_if.cs = 1'b0;
        bus_if.rd = 1'b0;
        #1;
        d = bus_if.databus_out;
        bus_if.cs = 1'b1;
        bus_if.rd = 1'b1;
    endtask

    task automatic read_word(input logic [3:0] base, output logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        read_reg(base, b0);
        read_reg(base + 4'd1, b1);
        read_reg(base + 4'd2, b2);
        read_reg(base + 4'd3, b3);
        w = {b3, b2, b1, b0};
    endtask

    task automatic load_ops(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        for (int k = 0; k < 4; k++) write_reg(4'(k), a[8*k +: 8]);
        for (int k = 0; k < 4; k++) write_reg(4'(k + 4), b[8*k +: 8]);
        write_reg(4'd8, {6'd0, op});
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus_if.cmd_end && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack_done(input string name);
        @(negedge clk);
        bus_if.end_ack = 1'b1;
        @(negedge clk);
        bus_if.end_ack = 1'b0;
        check({name, "_cmd_end_clr"}, {31'd0, bus_if.cmd_end}, 32'd0);
    endtask

    task automatic run_vec(input int idx);
        int          cyc;
        logic [31:0] r;
        string       nm;
        nm = $sformatf("vec%0d", idx);
        load_ops(vecs[idx].a, vecs[idx].b, vecs[idx].op);
        write_reg(4'd9, 8'h00);
        check({nm, "_busy"}, {31'd0, bus_if.busy}, 32'd1);
        wait_done(cyc);
        check({nm, "_latency_ok"}, {31'd0, (bus_if.cmd_end === 1'b1) && (cyc <= 64)}, 32'd1);
        read_word(4'd9, r);
        check({nm, "_result"}, r, vecs[idx].res);
        ack_done(nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [7:0]  d;
        logic [31:0] w;
        logic        held, seen;

        vecs[0]  = '{32'h40000000, 32'hC0000000, 2'd0, 32'h00000000};
        vecs[1]  = '{32'h40490FDA, 32'h402DF854, 2'd0, 32'h40BB8417};
        vecs[2]  = '{32'h40490FDA, 32'h402DF854, 2'd1, 32'h3ED8BC30};
        vecs[3]  = '{32'h3F800000, 32'h3F8CCCCD, 2'd2, 32'h3F8CCCCD};
        vecs[4]  = '{32'h40000000, 32'h41200000, 2'd2, 32'h41A00000};
        vecs[5]  = '{32'h3F800000, 32'h3F800000, 2'd0, 32'h40000000};
        vecs[6]  = '{32'h3F800000, 32'h33800000, 2'd0, 32'h3F800000};
        vecs[7]  = '{32'h3F800001, 32'h33800000, 2'd0, 32'h3F800002};
        vecs[8]  = '{32'h3FFFFFFF, 32'h33800000, 2'd0, 32'h40000000};
        vecs[9]  = '{32'h3F800001, 32'h3F800000, 2'd1, 32'h34000000};
        vecs[10] = '{32'h80800001, 32'h80800000, 2'd1, 32'h80000000};
        vecs[11] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 2'd0, 32'h7F800000};
        vecs[12] = '{32'h7F000000, 32'h40000000, 2'd2, 32'h7F800000};
        vecs[13] = '{32'h80800000, 32'h00800000, 2'd2, 32'h80000000};
        vecs[14] = '{32'h00000001, 32'h3F800000, 2'd0, 32'h3F800000};
        vecs[15] = '{32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000};
        vecs[16] = '{32'h7F800000, 32'h7F800000, 2'd1, 32'h7FC00000};
        vecs[17] = '{32'h00000000, 32'h7F800000, 2'd2, 32'h7FC00000};
        vecs[18] = '{32'h7F800000, 32'h3F800000, 2'd0, 32'h7F800000};
        vecs[19] = '{32'h3F800000, 32'h40000000, 2'd3, 32'h00000000};
        vecs[20] = '{32'hC0400000, 32'h40000000, 2'd2, 32'hC0C00000};
        vecs[21] = '{32'h3F800000, 32'h40000000, 2'd1, 32'hBF800000};

        bus_if.cs = 1'b1;
        bus_if.rd = 1'b1;
        bus_if.wr = 1'b1;
        bus_if.end_ack = 1'b0;
        bus_if.addr = 4'd0;
        bus_if.databus_in = 8'h00;
        arst = 1'b1;
        repeat (3) @(negedge clk);
        arst = 1'b0;

        check("reset_busy", {31'd0, bus_if.busy}, 32'd0);
        check("reset_cmd_end", {31'd0, bus_if.cmd_end}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), d);
            check($sformatf("reset_reg%0d", i), {24'd0, d}, 32'd0);
        end

        for (int i = 0; i < 22; i++) run_vec(i);

        // Bus idles at zero when not selected, even with a nonzero result held.
        @(negedge clk);
        bus_if.addr = 4'd10;
        bus_if.cs = 1'b0;
        #1;
        check("bus_unselected", {24'd0, bus_if.databus_out}, 32'd0);
        bus_if.cs = 1'b1;

        // Operand/opcode writes during busy are dropped.
        load_ops(32'h40000000, 32'h41200000, 2'd2);
        write_reg(4'd9, 8'h00);
        write_reg(4'd0, 8'hFF);
        write_reg(4'd8, 8'h00);
        wait_done(cyc);
        check("busy_wr_done", {31'd0, bus_if.cmd_end}, 32'd1);
        read_word(4'd0, w);
        check("busy_wr_opa", w, 32'h40000000);
        read_reg(4'd8, d);
        check("busy_wr_opcode", {24'd0, d}, 32'd2);
        read_word(4'd9, w);
        check("busy_wr_result", w, 32'h41A00000);
        read_reg(4'd13, d);
        check("status_done", {24'd0, d}, 32'd2);

        // cmd_end held without ack; START during cmd_end ignored.
        held = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (bus_if.cmd_end !== 1'b1) held = 1'b0;
        end
        write_reg(4'd0, 8'h00);
        write_reg(4'd3, 8'h3F);
        write_reg(4'd9, 8'h00);
        repeat (50) begin
            @(negedge clk);
            if (bus_if.cmd_end !== 1'b1 || bus_if.busy !== 1'b0) held = 1'b0;
        end
        check("cmd_end_hold", {31'd0, held}, 32'd1);
        read_word(4'd9, w);
        check("hold_result", w, 32'h41A00000);
        @(negedge clk);
        bus_if.end_ack = 1'b1;
        check("ack_before_edge", {31'd0, bus_if.cmd_end}, 32'd1);
        @(negedge clk);
        bus_if.end_ack = 1'b0;
        check("ack_after_edge", {31'd0, bus_if.cmd_end}, 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.busy !== 1'b0 || bus_if.cmd_end !== 1'b0) seen = 1'b1;
        end
        check("start_not_queued", {31'd0, seen}, 32'd0);

        // Reset in the middle of a multiply.
        load_ops(32'h40000000, 32'h41200000, 2'd2);
        write_reg(4'd9, 8'h00);
        repeat (5) @(negedge clk);
        check("mid_mul_busy", {31'd0, bus_if.busy}, 32'd1);
        arst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        check("abort_cmd_end", {31'd0, bus_if.cmd_end}, 32'd0);
        for (int i = 0; i < 14; i++) begin
            read_reg(4'(i), d);
            check($sformatf("abort_reg%0d", i), {24'd0, d}, 32'd0);
        end
        arst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus_if.cmd_end !== 1'b0 || bus_if.busy !== 1'b0) seen = 1'b1;
        end
        check("abort_no_cmd_end", {31'd0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
